utmi_tx_line_encoder: RTL and testbench
=======================================

Name: utmi_tx_line_encoder

Overview:
- Downstream neighbour of the UTMI transmitter serializer.
- Accepts the serial NRZ bit stream, applies USB bit stuffing (a 0 after six consecutive 1s) and NRZI encoding, and drives the differential line pair.
- Terminates each packet with an SE0/J end-of-packet sequence.
- Output is a registered line state: J (dp=1, dm=0), K (dp=0, dm=1), SE0 (dp=0, dm=0).

Parameters:
- EOP_SE0_BITS, 2: number of SE0 bit times in the EOP; legal range 1..7.
- STUFF_LIMIT, 6: number of consecutive 1s that triggers an inserted 0.

Ports:
- clk  in  1  bit-rate clock; one line bit per cycle.
- rst  in  1  reset, synchronous, active-high. Reset rst, synchronous, active-high; clock clk.
- bit_valid  in  1  upstream has a serial bit available.
- bit_data  in  1  NRZ data bit, in transmit order.
- bit_last  in  1  qualifies the final bit of the packet.
- bit_ready  out  1  encoder accepts bit this cycle (combinational from state).
- tx_en  out  1  line driver enable, registered.
- dp  out  1  D+ line level, registered.
- dm  out  1  D- line level, registered.
- busy  out  1  state != IDLE.
- underrun  out  1  one-cycle pulse: no valid bit in DATA state.

Behaviour:
- Reset values: dp=1, dm=0, tx_en=0, underrun=0, state=IDLE, ones_cnt=0.
  - busy=0 and bit_ready=1 after reset (both combinational from state).
  - Reset mid-packet aborts immediately; no EOP is generated, and the line returns to J at the next edge.
- Transfer: a bit is accepted on a clock edge when bit_valid && bit_ready.
- Latency: an accepted bit appears on dp/dm after that same edge, i.e. 1 cycle.
- NRZI: bit 0 toggles the line (J<->K); bit 1 holds the previous data level.
  - The level before the first bit is J.
  - Inserted stuff bits encode as 0, so they toggle the line.
- ones_cnt (3 bits):
  - Increments on an accepted 1.
  - Clears on an accepted 0, on a stuff bit, and in IDLE.
  - Never exceeds STUFF_LIMIT.
- State machine:
  - IDLE: bit_ready=1, tx_en=0, line J. On accept: tx_en<=1, encode the bit, then go to DATA.
    - If that accepted bit also has bit_last=1, the next state is STUFF or EOP_SE0, as in DATA.
  - DATA: bit_ready = (ones_cnt != STUFF_LIMIT).
    - On accept: encode the bit. If ones_cnt reaches STUFF_LIMIT, go to STUFF. Otherwise, if bit_last, go to EOP_SE0.
    - If bit_valid=0 while bit_ready=1: hold the line, pulse underrun, keep ones_cnt, stay in DATA.
  - STUFF: bit_ready=0; toggle the line, clear ones_cnt.
    - Then go to EOP_SE0 if the bit that caused the stuff carried bit_last; otherwise go to DATA.
    - A pending-last flag records this.
  - EOP_SE0: bit_ready=0; dp=0, dm=0 for EOP_SE0_BITS cycles (3-bit down-counter), then go to EOP_J.
  - EOP_J: bit_ready=0; drive J for 1 cycle, then go to IDLE with tx_en<=0 on that same edge.
- Packet length: a packet of N data bits with S stuff bits occupies N+S+EOP_SE0_BITS+1 line cycles.
- Back-to-back packets: a new packet may begin the first cycle after returning to IDLE. No minimum inter-packet gap is enforced here.
- bit_last while in STUFF or EOP is impossible because bit_ready=0 there. Inputs are ignored when not accepted.
- underrun is never asserted outside DATA.

Optional Feature:
- Macro: UTMI_TX_STUFF_STAT_EN.
- When defined:
  - Adds output stuff_count (8 bits), which counts inserted stuff bits in the current packet and saturates at 255.
  - stuff_count clears on the IDLE->DATA transition and on rst.
  - It holds its value through EOP and IDLE until the next packet starts.
- When undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset: assert rst 2 cycles -> dp=1, dm=0, tx_en=0, bit_ready=1, busy=0, underrun=0.
- SYNC: feed 0,0,0,0,0,0,0,1 then 1 with last -> dp sequence 0,1,0,1,0,1,0,0,0; then SE0, SE0, J; tx_en falls on the edge leaving EOP_J; 12 total cycles.
- Stuffing: feed 0, then 1,1,1,1,1,1, then 0 with last.
  - After the sixth 1, bit_ready=0 for exactly 1 cycle.
  - The stuff toggle appears, then the final 0 toggles again.
  - 9 data line cycles plus EOP.
- Stuff at end: last bit completes six 1s -> stuff bit emitted before the first SE0 cycle; stuff_count=1 when UTMI_TX_STUFF_STAT_EN is defined.
- Underrun: drop bit_valid for 2 cycles mid-packet -> line held, underrun high 2 cycles, ones_cnt preserved. Five 1s before plus one 1 after still triggers a stuff.
- Abort: assert rst during the 4th data bit -> next edge dp=1, dm=0, tx_en=0, busy=0, no SE0 observed.

Source files
------------

// File: rtl/utmi_tx_line_encoder.sv
// UTMI transmit line encoder: takes the serial NRZ stream from the serializer,
// inserts a stuff 0 after STUFF_LIMIT consecutive 1s, NRZI-encodes, drives the
// registered dp/dm pair and closes each packet with EOP_SE0_BITS of SE0 then J.
// Optional feature macro: UTMI_TX_STUFF_STAT_EN adds the stuff_count output.
module utmi_tx_line_encoder #(
  parameter int EOP_SE0_BITS = 2,
  parameter int STUFF_LIMIT  = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       bit_valid,
  input  logic       bit_data,
  input  logic       bit_last,
  output logic       bit_ready,
  output logic       tx_en,
  output logic       dp,
  output logic       dm,
  output logic       busy,
  output logic       underrun
`ifdef UTMI_TX_STUFF_STAT_EN
  ,
  output logic [7:0] stuff_count
`endif
);

  localparam logic [2:0] ONES_LIMIT = 3'(STUFF_LIMIT);
  localparam logic [2:0] EOP_INIT   = 3'(EOP_SE0_BITS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DATA,
    S_STUFF,
    S_EOP_SE0,
    S_EOP_J
  } state_t;

  state_t     state, state_nx;
  logic [2:0] ones_cnt, ones_nx, ones_acc;
  logic [2:0] eop_cnt, eop_nx;
  logic       pend_last, pend_nx;
  logic       level, level_nx, level_acc;  // NRZI data level, 1 = J
  logic       dp_nx, dm_nx, tx_en_nx, underrun_nx;
  logic       accept;

  // Handshake: only IDLE and DATA can take a bit, DATA stalls at the stuff limit.
  always_comb begin
    bit_ready = 1'b0;
    case (state)
      S_IDLE:  bit_ready = 1'b1;
      S_DATA:  bit_ready = (ones_cnt != ONES_LIMIT);
      default: bit_ready = 1'b0;
    endcase
  end

  assign accept = bit_valid && bit_ready;
  assign busy   = (state != S_IDLE);

  // Next-state and next-line-state logic for every state.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis would infer a latch to hold the old value.
    state_nx    = state;
    ones_nx     = ones_cnt;
    eop_nx      = eop_cnt;
    pend_nx     = pend_last;
    level_nx    = level;
    dp_nx       = dp;
    dm_nx       = dm;
    tx_en_nx    = tx_en;
    underrun_nx = 1'b0;

    // A packet always starts from J with an empty run of ones.
    ones_acc  = bit_data ? (((state == S_IDLE) ? 3'd0 : ones_cnt) + 3'd1) : 3'd0;
    level_acc = ((state == S_IDLE) ? 1'b1 : level) ^ ~bit_data;

    case (state)
      S_IDLE, S_DATA: begin
        if (accept) begin
          ones_nx  = ones_acc;
          level_nx = level_acc;
          dp_nx    = level_acc;
          dm_nx    = ~level_acc;
          tx_en_nx = 1'b1;
          if (ones_acc == ONES_LIMIT) begin
            state_nx = S_STUFF;
            pend_nx  = bit_last;
          end else if (bit_last) begin
            state_nx = S_EOP_SE0;
            eop_nx   = EOP_INIT;
          end else begin
            state_nx = S_DATA;
          end
        end else if (state == S_IDLE) begin
          ones_nx  = 3'd0;
          level_nx = 1'b1;
          dp_nx    = 1'b1;
          dm_nx    = 1'b0;
          tx_en_nx = 1'b0;
        end else if (bit_ready) begin
          underrun_nx = 1'b1;
        end
      end
      S_STUFF: begin
        level_nx = ~level;
        dp_nx    = ~level;
        dm_nx    = level;
        ones_nx  = 3'd0;
        pend_nx  = 1'b0;
        if (pend_last) begin
          state_nx = S_EOP_SE0;
          eop_nx   = EOP_INIT;
        end else begin
          state_nx = S_DATA;
        end
      end
      S_EOP_SE0: begin
        dp_nx = 1'b0;
        dm_nx = 1'b0;
        if (eop_cnt <= 3'd1) state_nx = S_EOP_J;
        else                 eop_nx   = eop_cnt - 3'd1;
      end
      S_EOP_J: begin
        dp_nx    = 1'b1;
        dm_nx    = 1'b0;
        level_nx = 1'b1;
        tx_en_nx = 1'b0;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // State and registered line outputs; reset aborts any packet straight to J.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      state     <= S_IDLE;
      ones_cnt  <= 3'd0;
      eop_cnt   <= 3'd0;
      pend_last <= 1'b0;
      level     <= 1'b1;
      dp        <= 1'b1;
      dm        <= 1'b0;
      tx_en     <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      state     <= state_nx;
      ones_cnt  <= ones_nx;
      eop_cnt   <= eop_nx;
      pend_last <= pend_nx;
      level     <= level_nx;
      dp        <= dp_nx;
      dm        <= dm_nx;
      tx_en     <= tx_en_nx;
      underrun  <= underrun_nx;
    end
  end

`ifdef UTMI_TX_STUFF_STAT_EN
  // Per-packet stuff-bit counter: cleared when a packet starts, saturates at 255.
  always_ff @(posedge clk) begin
    if (rst) begin
      stuff_count <= 8'd0;
    end else if (state == S_IDLE && accept) begin
      stuff_count <= 8'd0;
    end else if (state == S_STUFF && stuff_count != 8'hFF) begin
      stuff_count <= stuff_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_utmi_tx_line_encoder.sv
// Testbench for utmi_tx_line_encoder. A driver plays packets cycle by cycle and
// pushes the expected handshake/line state of each cycle into a queue; a
// monitor pops the queue on falling edges and compares against the DUT.
module tb_utmi_tx_line_encoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       bit_valid = 1'b0;
  logic       bit_data = 1'b0;
  logic       bit_last = 1'b0;
  logic       bit_ready, tx_en, dp, dm, busy, underrun;
`ifdef UTMI_TX_STUFF_STAT_EN
  logic [7:0] stuff_count;
`endif

  utmi_tx_line_encoder dut (
    .clk       (clk),
    .rst       (rst),
    .bit_valid (bit_valid),
    .bit_data  (bit_data),
    .bit_last  (bit_last),
    .bit_ready (bit_ready),
    .tx_en     (tx_en),
    .dp        (dp),
    .dm        (dm),
    .busy      (busy),
    .underrun  (underrun)
`ifdef UTMI_TX_STUFF_STAT_EN
    ,
    .stuff_count (stuff_count)
`endif
  );

  always #5 clk = ~clk;

  // One record per driven cycle: handshake seen during the cycle, line after its edge.
  typedef struct {
    bit         chk_pre;
    bit         ready;
    bit         busy;
    bit         dp;
    bit         dm;
    bit         tx_en;
    bit         underrun;
    logic [7:0] sc;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   model_sc = 0;
  bit   pkt_bits[$];
  int   pkt_gaps[$];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pre-edge handshake checked on pop, line state checked one cycle later.
  initial begin
    exp_t pend;
    bit   have = 1'b0;
    forever begin
      @(negedge clk);
      if (have) begin
        check("dp", {7'd0, dp}, {7'd0, pend.dp});
        check("dm", {7'd0, dm}, {7'd0, pend.dm});
        check("tx_en", {7'd0, tx_en}, {7'd0, pend.tx_en});
        check("underrun", {7'd0, underrun}, {7'd0, pend.underrun});
`ifdef UTMI_TX_STUFF_STAT_EN
        check("stuff_count", stuff_count, pend.sc);
`endif
        have = 1'b0;
      end
      if (exp_q.size() > 0) begin
        pend = exp_q.pop_front();
        if (pend.chk_pre) begin
          check("bit_ready", {7'd0, bit_ready}, {7'd0, pend.ready});
          check("busy", {7'd0, busy}, {7'd0, pend.busy});
        end
        have = 1'b1;
      end
    end
  end

  // Drive one cycle of inputs and record what the spec says must be seen.
  task automatic cycle(input bit v, input bit d, input bit l, input bit r,
                       input bit chk, input bit rdy, input bit bsy,
                       input bit edp, input bit edm, input bit etx, input bit eun);
    exp_t e;
    @(posedge clk);
    #1;
    bit_valid = v;
    bit_data  = d;
    bit_last  = l;
    rst       = r;
    e.chk_pre  = chk;
    e.ready    = rdy;
    e.busy     = bsy;
    e.dp       = edp;
    e.dm       = edm;
    e.tx_en    = etx;
    e.underrun = eun;
    e.sc       = 8'(model_sc);
    exp_q.push_back(e);
  endtask

  function automatic bit junk();
    return bit'($urandom_range(0, 1));
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, junk(), junk(), 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  // Reference model: walks the packet as a list of bits with optional gaps,
  // tracking only the NRZI level and the current run of ones.
  task automatic run_packet(input int abort_at);
    bit lvl  = 1'b1;
    int ones = 0;
    int n    = pkt_bits.size();
    for (int i = 0; i < n; i++) begin
      bit b    = pkt_bits[i];
      bit last = (i == n - 1);
      if (i > 0) begin
        for (int g = 0; g < pkt_gaps[i]; g++)
          cycle(1'b0, junk(), junk(), 1'b0, 1'b1, 1'b1, 1'b1, lvl, !lvl, 1'b1, 1'b1);
      end
      if (i == abort_at) begin
        model_sc = 0;
        cycle(1'b1, b, last, 1'b1, 1'b1, 1'b1, i > 0, 1'b1, 1'b0, 1'b0, 1'b0);
        return;
      end
      if (i == 0) model_sc = 0;
      if (b) ones++;
      else begin
        ones = 0;
        lvl  = !lvl;
      end
      cycle(1'b1, b, last, 1'b0, 1'b1, 1'b1, i > 0, lvl, !lvl, 1'b1, 1'b0);
      if (ones == 6) begin
        ones = 0;
        lvl  = !lvl;
        if (model_sc < 255) model_sc++;
        cycle(junk(), junk(), junk(), 1'b0, 1'b1, 1'b0, 1'b1, lvl, !lvl, 1'b1, 1'b0);
      end
    end
    for (int s = 0; s < 2; s++)
      cycle(junk(), junk(), junk(), 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    cycle(junk(), junk(), junk(), 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic load(input logic [63:0] bits, input int len);
    pkt_bits.delete();
    pkt_gaps.delete();
    for (int i = 0; i < len; i++) begin
      pkt_bits.push_back(bits[len - 1 - i]);
      pkt_gaps.push_back(0);
    end
  endtask

  // Stimulus: directed cases from the test plan, then randomized packets.
  initial begin
    model_sc = 0;
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(2);

    load(64'b0000000_11, 9);           // SYNC plus a trailing 1
    run_packet(-1);
    idle(1);
    load(64'b0_111111_0, 8);           // stuff mid-packet
    run_packet(-1);
    idle(2);
    load(64'b10_111111, 8);            // last bit completes six ones
    run_packet(-1);
    load(64'b0_11111_1_0, 8);          // back-to-back, underrun before sixth one
    pkt_gaps[6] = 2;
    run_packet(-1);
    idle(1);
    load(64'b0101_0101, 8);            // reset during the 4th bit
    run_packet(3);
    idle(3);
    load(64'b11111111111111, 14);      // two stuffs in one packet
    run_packet(-1);
    load(64'b1, 1);                    // single-bit packet
    run_packet(-1);
    idle(1);

    for (int p = 0; p < 40; p++) begin
      int len = $urandom_range(1, 40);
      pkt_bits.delete();
      pkt_gaps.delete();
      for (int i = 0; i < len; i++) begin
        pkt_bits.push_back($urandom_range(0, 3) != 0);
        pkt_gaps.push_back(($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 2)) : 0);
      end
      run_packet(($urandom_range(0, 19) == 0) ? int'($urandom_range(0, len - 1)) : -1);
      idle($urandom_range(0, 2));
    end

    idle(1);
    repeat (3) @(negedge clk);
    #1;
    check("queue_drained", 8'(exp_q.size()), 8'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
